text_glyph_draw_ctrl: RTL
=========================

// Module: text_glyph_draw_ctrl
// PURPOSE
//  Sequences one character-cell draw. Accepts a request (char, x, y, fg/bg colour),
//  fetches the glyph from the font ROM, and walks its FONT_W*FONT_H pixels row-major.
//  Issues one framebuffer pixel write per visible pixel over a valid/ready handshake.
//  Sits between the text/console logic and the VGA framebuffer write port.
// PARAMETERS
//  FONT_W   10   glyph width in pixels
//  FONT_H   12   glyph height in pixels
//  SCR_W    320  screen width; x >= SCR_W is off-limits
//  SCR_H    240  screen height; y >= SCR_H is off-limits
//  COLOR_W  16   pixel colour width
// PORTS
//  clk            in   1                   system clock
//  rst            in   1                   synchronous reset, active-high
//  req_valid      in   1                   draw request present
//  req_ready      out  1                   1 only in IDLE; accept = req_valid & req_ready
//  req_char       in   7                   ASCII code
//  req_x          in   $clog2(SCR_W)       cell top-left x
//  req_y          in   $clog2(SCR_H)       cell top-left y
//  req_fg         in   COLOR_W             colour for glyph bit = 1
//  req_bg         in   COLOR_W             colour for glyph bit = 0
//  req_transp     in   1                   1: bit-0 pixels are skipped (no write)
//  font_mem_addr  out  $clog2(95)          glyph index = char-32; registered
//  font_mem_dout  in   FONT_W*FONT_H       glyph bitmap, bit fi=row*FONT_W+col; sync ROM, 1-cycle latency
//  fb_wr_valid    out  1                   pixel write valid
//  fb_wr_ready    in   1                   framebuffer accepts write
//  fb_x / fb_y    out  $clog2(SCR_W)/$clog2(SCR_H)   pixel coordinate
//  fb_data        out  COLOR_W             pixel colour
//  busy           out  1                   state != IDLE
//  done           out  1                   1-cycle pulse when the cell completes
//  bad_char       out  1                   1-cycle pulse at accept if char outside 32..126
// BEHAVIOUR
//  Reset: state IDLE; req_ready=1; fb_wr_valid, busy, done, bad_char=0; font_mem_addr=0; fb_x/fb_y/fb_data=0.
//  FSM: IDLE -> FETCH -> LATCH -> DRAW -> DONE -> IDLE.
//   IDLE : on accept, latch all req_* fields. font_mem_addr <= char-32, or 0 if non-printable.
//   FETCH: 1 cycle, ROM access in flight.
//   LATCH: glyph register <= font_mem_dout. If non-printable, glyph register <= 0 (blank cell). fi=0.
//   DRAW : one pixel index fi per step; col = fi % FONT_W, row = fi / FONT_W (counters, no divider).
//          Pixel coordinates px = x+col and py = y+row, computed one bit wider (no wrap-around).
//          Skip (no write, 1 cycle) if px >= SCR_W, py >= SCR_H, or (bit=0 & transp).
//          Otherwise assert fb_wr_valid with fb_x/fb_y/fb_data = bit ? fg : bg.
//          Hold all fb_* fields stable until fb_wr_ready, then advance.
//          After fi = FONT_W*FONT_H-1 completes -> DONE.
//   DONE : done=1 for one cycle -> IDLE.
//  Latency: accept at edge T with fb_wr_ready tied 1 and all pixels visible -> done high in cycle T+3+FONT_W*FONT_H.
//  New req_valid while busy: ignored; the requester holds it until req_ready.
//  rst asserted mid-draw: next edge returns to IDLE and drops fb_wr_valid; the partial cell is abandoned, no done.
//  fb_wr_valid, once raised, is never withdrawn except by rst.
// STRUCTURE
//  Shared include font_defs.vh: FONT_W/FONT_H defaults, ASCII_FIRST=32, ASCII_LAST=126,
//  NUM_GLYPHS=95, FSM state encodings.
//  One sub-module: glyph_cursor (fi/col/row counters with advance, clear and last outputs).
// TESTING
//  1. 'A' (65) at (0,0), ready=1, transp=0 -> font_mem_addr=33; 120 writes in row-major order; done at T+123.
//  2. Char 0x7F at (10,10) -> bad_char pulse; 120 writes, all = bg; done pulses.
//  3. ' ' at (315,235), transp=0 -> only cols 0..4 x rows 0..4 written (25 writes); no coordinate wraps.
//  4. '!' with transp=1 -> writes only where glyph bit=1, all = fg; count matches ROM popcount.
//  5. fb_wr_ready toggled randomly -> fb_* held stable while valid & !ready; no pixel lost or duplicated.
//  6. rst high at pixel 50 -> next cycle IDLE, fb_wr_valid=0, req_ready=1, no done; next request draws fully.

Source files
------------

// File: rtl/text_glyph_draw_ctrl_pkg.sv
// Shared font geometry, ASCII range and FSM encodings for the glyph draw controller.
package text_glyph_draw_ctrl_pkg;

  localparam int FONT_W_DEF = 10;
  localparam int FONT_H_DEF = 12;
  localparam int NUM_GLYPHS = 95;

  localparam logic [6:0] ASCII_FIRST = 7'd32;
  localparam logic [6:0] ASCII_LAST  = 7'd126;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_FETCH = 3'd1;
  localparam logic [2:0] ST_LATCH = 3'd2;
  localparam logic [2:0] ST_DRAW  = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  function automatic logic is_printable(input logic [6:0] c);
    return (c >= ASCII_FIRST) && (c <= ASCII_LAST);
  endfunction

endpackage

// File: rtl/text_glyph_draw_ctrl_glyph_cursor.sv
// Row-major pixel walker over one glyph: flat index plus col/row counters, no divider.
module text_glyph_draw_ctrl_glyph_cursor #(
  parameter int FONT_W = 10,
  parameter int FONT_H = 12
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  clr,
  input  logic                                  adv,
  output logic [$clog2(FONT_W*FONT_H)-1:0]      fi,
  output logic [$clog2(FONT_W)-1:0]             col,
  output logic [$clog2(FONT_H)-1:0]             row,
  output logic                                  last
);
  localparam int NPIX = FONT_W * FONT_H;
  localparam int FW   = $clog2(NPIX);
  localparam int CW   = $clog2(FONT_W);
  localparam int RW   = $clog2(FONT_H);

  assign last = (fi == FW'(NPIX - 1));

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      fi  <= '0;
      col <= '0;
      row <= '0;
    end else if (adv) begin
      fi <= fi + 1'b1;
      if (col == CW'(FONT_W - 1)) begin
        col <= '0;
        row <= row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

endmodule

// File: rtl/text_glyph_draw_ctrl.sv
// Draws one character cell: fetch glyph from the font ROM, then stream visible pixels to the framebuffer.
module text_glyph_draw_ctrl
  import text_glyph_draw_ctrl_pkg::*;
#(
  parameter int FONT_W  = FONT_W_DEF,
  parameter int FONT_H  = FONT_H_DEF,
  parameter int SCR_W   = 320,
  parameter int SCR_H   = 240,
  parameter int COLOR_W = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic [6:0]                    req_char,
  input  logic [$clog2(SCR_W)-1:0]      req_x,
  input  logic [$clog2(SCR_H)-1:0]      req_y,
  input  logic [COLOR_W-1:0]            req_fg,
  input  logic [COLOR_W-1:0]            req_bg,
  input  logic                          req_transp,
  output logic [$clog2(NUM_GLYPHS)-1:0] font_mem_addr,
  input  logic [FONT_W*FONT_H-1:0]      font_mem_dout,
  output logic                          fb_wr_valid,
  input  logic                          fb_wr_ready,
  output logic [$clog2(SCR_W)-1:0]      fb_x,
  output logic [$clog2(SCR_H)-1:0]      fb_y,
  output logic [COLOR_W-1:0]            fb_data,
  output logic                          busy,
  output logic                          done,
  output logic                          bad_char
);
  localparam int XW   = $clog2(SCR_W);
  localparam int YW   = $clog2(SCR_H);
  localparam int AW   = $clog2(NUM_GLYPHS);
  localparam int NPIX = FONT_W * FONT_H;
  localparam int FW   = $clog2(NPIX);
  localparam int CW   = $clog2(FONT_W);
  localparam int RW   = $clog2(FONT_H);

  typedef struct packed {
    logic [6:0]         ch;
    logic [XW-1:0]      x;
    logic [YW-1:0]      y;
    logic [COLOR_W-1:0] fg;
    logic [COLOR_W-1:0] bg;
    logic               transp;
  } req_t;

  logic [2:0]      state;
  req_t            req_q;
  logic            printable_q;
  logic [NPIX-1:0] glyph_q;

  logic [FW-1:0]   fi;
  logic [CW-1:0]   col;
  logic [RW-1:0]   row;
  logic            last;
  logic            cur_clr;
  logic            cur_adv;

  logic [XW:0]     px;
  logic [YW:0]     py;
  logic            pix_bit;
  logic            visible;
  logic            write_px;
  logic            in_draw;
  logic            accept;

  text_glyph_draw_ctrl_glyph_cursor #(
    .FONT_W (FONT_W),
    .FONT_H (FONT_H)
  ) u_cursor (
    .clk  (clk),
    .rst  (rst),
    .clr  (cur_clr),
    .adv  (cur_adv),
    .fi   (fi),
    .col  (col),
    .row  (row),
    .last (last)
  );

  // One extra bit so cells hanging off the right/bottom edge clip instead of wrapping.
  assign px       = {1'b0, req_q.x} + (XW+1)'(col);
  assign py       = {1'b0, req_q.y} + (YW+1)'(row);
  assign pix_bit  = glyph_q[fi];
  assign visible  = (px < (XW+1)'(SCR_W)) && (py < (YW+1)'(SCR_H));
  assign write_px = visible && (pix_bit || !req_q.transp);

  assign in_draw  = (state == ST_DRAW);
  assign accept   = req_valid && req_ready;
  assign req_ready = (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);
  assign done      = (state == ST_DONE);

  // Skipped pixels cost one cycle; written pixels stall on fb_wr_ready, keeping fb_* stable.
  assign cur_clr  = (state == ST_LATCH);
  assign cur_adv  = in_draw && (!write_px || fb_wr_ready);

  assign fb_wr_valid = in_draw && write_px;
  assign fb_x        = fb_wr_valid ? px[XW-1:0] : '0;
  assign fb_y        = fb_wr_valid ? py[YW-1:0] : '0;
  assign fb_data     = fb_wr_valid ? (pix_bit ? req_q.fg : req_q.bg) : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      req_q         <= '0;
      printable_q   <= 1'b0;
      glyph_q       <= '0;
      font_mem_addr <= '0;
      bad_char      <= 1'b0;
    end else begin
      bad_char <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            req_q.ch      <= req_char;
            req_q.x       <= req_x;
            req_q.y       <= req_y;
            req_q.fg      <= req_fg;
            req_q.bg      <= req_bg;
            req_q.transp  <= req_transp;
            printable_q   <= is_printable(req_char);
            font_mem_addr <= is_printable(req_char) ? AW'(req_char - ASCII_FIRST) : '0;
            bad_char      <= !is_printable(req_char);
            state         <= ST_FETCH;
          end
        end
        ST_FETCH: state <= ST_LATCH;
        ST_LATCH: begin
          // Non-printable codes draw as a blank cell in the background colour.
          glyph_q <= printable_q ? font_mem_dout : '0;
          state   <= ST_DRAW;
        end
        ST_DRAW: begin
          if (cur_adv && last) state <= ST_DONE;
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
